// File: rtl/clk_rst_seq.sv
// clk_rst_seq
//   Board-level clock/reset sequencer for the detection datapath.
//   Synchronizes the raw async reset, holds every channel in reset for
//   HOLD_CYCLES, then releases channels one by one, STAGGER cycles apart.
//   Each released channel gets a clock-enable strobe with period div+1.
//   A software re-sequence request (sw_rst) restarts from the hold phase.
// Ports
//   clk      system clock, rising edge
//   rst      async active-high reset
//   sw_rst   sync one-cycle re-sequence request
//   div_i    per-channel divide value, ch k at [k*DIV_W +: DIV_W]
//   rst_o    per-channel reset, active-high, registered
//   ce_o     per-channel clock enable, registered
//   ready_o  high once all channels are released

// Per-channel clock-enable generator.
//   go   : this edge releases the channel (rst_cur is still 1)
//   clr  : re-sequence, drop back to idle
//   cnt holds the position inside the current period; ce is high in the
//   cycle where cnt equals the latched divide value.
module clk_rst_seq_lane #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_cur,
  input  logic             go,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);
  logic [DIV_W-1:0] cnt, d, cnt_inc;

  // cnt < d whenever it is incremented, so this never wraps.
  assign cnt_inc = cnt + DIV_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      d   <= '0;
      ce  <= 1'b0;
    end else if (clr || (rst_cur && !go)) begin
      cnt <= '0;
      d   <= div;
      ce  <= 1'b0;
    end else if (rst_cur || ce) begin
      // Release edge or end of a pulse cycle: start a new period with a
      // freshly latched divide value. ce is computed one edge ahead so a
      // zero divide pulses already in the first released cycle.
      cnt <= '0;
      d   <= div;
      ce  <= (div == '0);
    end else begin
      cnt <= cnt_inc;
      ce  <= (cnt_inc == d);
    end
  end
endmodule

module clk_rst_seq #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGGER     = 4,
  parameter int DIV_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_rst,
  input  logic [N_CH*DIV_W-1:0]   div_i,
  output logic [N_CH-1:0]         rst_o,
  output logic [N_CH-1:0]         ce_o,
  output logic                    ready_o
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int IW = $clog2(N_CH + 1);

  typedef enum logic [1:0] {S_SYNC, S_HOLD, S_REL, S_RUN} state_t;

  state_t           state;
  logic [SYNC_STAGES-1:0] sync;
  logic             rst_i;
  logic [HW-1:0]    hold_cnt;
  logic [SW-1:0]    stg_cnt;
  logic [IW-1:0]    idx;       // next channel to release; N_CH = all done
  logic [N_CH-1:0]  rel_stb;   // channels released on this edge
  logic             sw_take;

  // Async-assert, sync-deassert reset chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], 1'b0};
  end
  assign rst_i = sync[SYNC_STAGES-1];

  // Re-sequence only once the FSM has left SYNC; in SYNC it is already
  // heading into a fresh hold phase.
  assign sw_take = !rst_i && sw_rst && (state != S_SYNC);

  // Release decision is shared with the lanes so their first ce can be
  // registered on the same edge that drops rst_o.
  always_comb begin
    rel_stb = '0;
    if (!rst_i && !sw_rst) begin
      if (state == S_HOLD && hold_cnt == HW'(HOLD_CYCLES - 1))
        rel_stb[0] = 1'b1;
      if (state == S_REL && stg_cnt == SW'(STAGGER - 1))
        for (int k = 0; k < N_CH; k++)
          if (idx == IW'(k)) rel_stb[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_SYNC;
      rst_o    <= '1;
      ready_o  <= 1'b0;
      hold_cnt <= '0;
      stg_cnt  <= '0;
      idx      <= '0;
    end else if (sw_take) begin
      state    <= S_HOLD;
      rst_o    <= '1;
      ready_o  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      rst_o <= rst_o & ~rel_stb;
      case (state)
        S_SYNC: begin
          if (!rst_i) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state   <= S_REL;
            stg_cnt <= '0;
            idx     <= IW'(1);   // ch0 drops on this edge
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_REL: begin
          if (idx == IW'(N_CH)) begin
            state   <= S_RUN;
            ready_o <= 1'b1;
          end else if (stg_cnt == SW'(STAGGER - 1)) begin
            idx     <= idx + IW'(1);
            stg_cnt <= '0;
          end else begin
            stg_cnt <= stg_cnt + SW'(1);
          end
        end
        default: ;  // S_RUN: wait for rst or sw_rst
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    clk_rst_seq_lane #(.DIV_W(DIV_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .rst_cur (rst_o[g]),
      .go      (rel_stb[g]),
      .clr     (sw_take),
      .div     (div_i[g*DIV_W +: DIV_W]),
      .ce      (ce_o[g])
    );
  end
endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: default 4-channel build plus a 1-channel,
// HOLD_CYCLES=1, STAGGER=1 build sharing rst/sw_rst.
// Reference model works on absolute edge numbers: each channel's release
// edge is computed from when the sequence started, and each ce pulse is
// scheduled as "previous period start + latched divide".
module tb_clk_rst_seq;
  localparam int N = 4, SS = 2, HC = 8, ST = 4, DW = 8;

  logic clk = 1'b0;
  logic rst, sw_rst;
  logic [N*DW-1:0] div_i;
  logic [N-1:0]    rst_o, ce_o;
  logic            ready_o;
  logic [DW-1:0]   div1;
  logic [0:0]      rst_o1, ce_o1;
  logic            ready1;

  int n_cmp = 0, n_bad = 0;
  int edge_n = 0, base = 0, base1 = 0, np1 = 0;
  int np[N];
  bit seq_on = 0;

  always #5 clk = ~clk;

  clk_rst_seq #(.N_CH(N), .SYNC_STAGES(SS), .HOLD_CYCLES(HC), .STAGGER(ST), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .div_i(div_i),
    .rst_o(rst_o), .ce_o(ce_o), .ready_o(ready_o));

  clk_rst_seq #(.N_CH(1), .SYNC_STAGES(SS), .HOLD_CYCLES(1), .STAGGER(1), .DIV_W(DW)) dut1 (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .div_i(div1),
    .rst_o(rst_o1), .ce_o(ce_o1), .ready_o(ready1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_o"}, 32'(rst_o), 32'hF);
    chk({tag, "_ce_o"},  32'(ce_o), 32'h0);
    chk({tag, "_ready"}, 32'(ready_o), 32'h0);
    chk({tag, "_rst_o1"}, 32'(rst_o1), 32'h1);
    chk({tag, "_ce_o1"}, 32'(ce_o1), 32'h0);
  endtask

  // rst falls now: ch0 of the main build drops SS+HC+1 edges later,
  // the single-channel build SS+1+1 edges later.
  task automatic start_seq();
    rst    = 1'b0;
    seq_on = 1'b1;
    base   = edge_n + SS + HC + 1;
    base1  = edge_n + SS + 2;
  endtask

  task automatic tick();
    logic [N*DW-1:0] dv;
    logic [DW-1:0]   dv1;
    logic            sw, r, rel;
    logic [N-1:0]    er, ec;
    logic            er1, ec1, ery, ery1;
    int              re;
    dv = div_i; dv1 = div1; sw = sw_rst; r = rst;
    @(posedge clk);
    edge_n++;
    if (seq_on && sw && !r) begin
      base  = edge_n + HC;
      base1 = edge_n + 1;
    end
    for (int k = 0; k < N; k++) begin
      re  = base + k * ST;
      rel = seq_on && (edge_n >= re);
      if (rel && (edge_n == re || np[k] == edge_n - 1))
        np[k] = edge_n + int'(dv[k*DW +: DW]);
      er[k] = !rel;
      ec[k] = rel && (np[k] == edge_n);
    end
    ery = seq_on && (edge_n >= base + (N - 1) * ST + 1);
    rel = seq_on && (edge_n >= base1);
    if (rel && (edge_n == base1 || np1 == edge_n - 1))
      np1 = edge_n + int'(dv1);
    er1  = !rel;
    ec1  = rel && (np1 == edge_n);
    ery1 = seq_on && (edge_n >= base1 + 1);
    @(negedge clk);
    chk("rst_o",   32'(rst_o),   32'(er));
    chk("ce_o",    32'(ce_o),    32'(ec));
    chk("ready_o", 32'(ready_o), 32'(ery));
    chk("rst_o1",  32'(rst_o1),  32'(er1));
    chk("ce_o1",   32'(ce_o1),   32'(ec1));
    chk("ready1",  32'(ready1),  32'(ery1));
  endtask

  initial begin
    rst    = 1'b1;
    sw_rst = 1'b0;
    div_i  = {8'($urandom_range(0, 15)), 8'd255, 8'd3, 8'd0};
    div1   = 8'($urandom_range(0, 5));
    #1;
    chk_reset_vals("por");
    repeat (5) tick();

    // Power-up sequence, ch0=0 / ch1=3 / ch2=255 dividers.
    start_seq();
    repeat (32) tick();

    // ch1 divide 3 -> 1 in the middle of a period.
    div_i[15:8] = 8'd1;
    repeat (20) tick();

    // Random divider changes on ch1/ch3 and the small build; ch2 stays at
    // 255 long enough to show two full 256-cycle periods.
    for (int i = 0; i < 14; i++) begin
      div_i[31:24] = 8'($urandom_range(0, 9));
      div_i[15:8]  = 8'($urandom_range(0, 6));
      div1         = 8'($urandom_range(0, 4));
      repeat (40 + $urandom_range(0, 3)) tick();
    end

    // Software re-sequence from RUN.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    repeat (30) tick();

    // Async rst between edges while the main build is in REL.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    repeat (HC + 6) tick();
    #2;
    rst    = 1'b1;
    seq_on = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (4) tick();
    start_seq();
    repeat (30) tick();

    // rst and sw_rst together: rst wins, then a clean sequence.
    rst    = 1'b1;
    sw_rst = 1'b1;
    seq_on = 1'b0;
    #1;
    chk_reset_vals("both");
    repeat (3) tick();
    sw_rst = 1'b0;
    start_seq();
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
